// File: rtl/m_seq_checker.sv
// Self-synchronising m-sequence receive checker.
// Hunts, verifies, then flywheels a local LFSR copy and counts bit errors.
module m_seq_checker #(
  parameter int         W        = 8,
  parameter logic [W:0] POLY     = 9'h11D,
  parameter int         VERIFY_N = 16,
  parameter int         WIN      = 64,
  parameter int         LOSS_THR = 8,
  parameter int         ERR_W    = 16,
  parameter int         BIT_W    = 32
) (
  input  logic             clk,
  input  logic             nCR,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             clr,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic             loss_pulse,
  output logic [ERR_W-1:0] err_total,
  output logic [BIT_W-1:0] bit_total
);

  localparam int FW = $clog2(W + 1);
  localparam int VW = $clog2(VERIFY_N + 1);
  localparam int CW = $clog2(WIN + 1);
  localparam int EW = $clog2(LOSS_THR + 1);

  localparam logic [FW-1:0] FILL_MAX = FW'(W);
  localparam logic [VW-1:0] V_LAST   = VW'(VERIFY_N - 1);
  localparam logic [CW-1:0] WIN_MAX  = CW'(WIN);
  localparam logic [EW-1:0] THR      = EW'(LOSS_THR);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } st_e;

  st_e              state_q, state_d;
  logic [W-1:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d, fill_n;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic [CW-1:0]    wcnt_q, wcnt_d, wcnt_n;
  logic [EW-1:0]    werr_q, werr_d, werr_n;
  logic             errp_q, errp_d;
  logic             lossp_q, lossp_d;
  logic [ERR_W-1:0] etot_q, etot_d;
  logic [BIT_W-1:0] btot_q, btot_d;
  logic             pred, err;

  assign pred = ^(hist_q & POLY[W:1]);
  assign err  = bit_in ^ pred;

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    vcnt_d  = vcnt_q;
    wcnt_d  = wcnt_q;
    werr_d  = werr_q;
    etot_d  = etot_q;
    btot_d  = btot_q;
    errp_d  = 1'b0;
    lossp_d = 1'b0;
    fill_n  = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
    wcnt_n  = wcnt_q + 1'b1;
    werr_n  = werr_q + EW'(err);
    if (bit_en) begin
      case (state_q)
        VERIFY: begin
          hist_d = {hist_q[W-2:0], bit_in};
          if (err) begin
            state_d = HUNT;
            fill_d  = '0;
          end else if (vcnt_q == V_LAST) begin
            state_d = LOCK;
            vcnt_d  = '0;
            wcnt_d  = '0;
            werr_d  = '0;
          end else begin
            vcnt_d = vcnt_q + 1'b1;
          end
        end
        LOCK: begin
          // flywheel: the prediction, not the received bit, feeds history
          hist_d = {hist_q[W-2:0], pred};
          errp_d = err;
          if (btot_q != '1) btot_d = btot_q + 1'b1;
          if (err && etot_q != '1) etot_d = etot_q + 1'b1;
          if (werr_n == THR) begin
            lossp_d = 1'b1;
            state_d = HUNT;
            fill_d  = '0;
            wcnt_d  = '0;
            werr_d  = '0;
          end else if (wcnt_n == WIN_MAX) begin
            wcnt_d = '0;
            werr_d = '0;
          end else begin
            wcnt_d = wcnt_n;
            werr_d = werr_n;
          end
        end
        default: begin
          state_d = HUNT;
          hist_d  = {hist_q[W-2:0], bit_in};
          fill_d  = fill_n;
          // an all-zero history keeps sliding so a dead line never locks
          if (fill_n == FILL_MAX && hist_d != '0) begin
            state_d = VERIFY;
            vcnt_d  = '0;
          end
        end
      endcase
    end
    if (clr) begin
      etot_d = '0;
      btot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      state_q <= HUNT;
      hist_q  <= '0;
      fill_q  <= '0;
      vcnt_q  <= '0;
      wcnt_q  <= '0;
      werr_q  <= '0;
      errp_q  <= 1'b0;
      lossp_q <= 1'b0;
      etot_q  <= '0;
      btot_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      vcnt_q  <= vcnt_d;
      wcnt_q  <= wcnt_d;
      werr_q  <= werr_d;
      errp_q  <= errp_d;
      lossp_q <= lossp_d;
      etot_q  <= etot_d;
      btot_q  <= btot_d;
    end
  end

  assign locked     = (state_q == LOCK);
  assign state      = state_q;
  assign err_pulse  = errp_q;
  assign loss_pulse = lossp_q;
  assign err_total  = etot_q;
  assign bit_total  = btot_q;

endmodule

// File: tb/tb_m_seq_checker.sv
// Directed bench for m_seq_checker.
// A Galois LFSR (POLY 0x11D, seed 0x01) supplies the reference stream.
module tb_m_seq_checker;

  logic        clk = 1'b0;
  logic        nCR = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_en = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic [1:0]  state;
  logic        err_pulse;
  logic        loss_pulse;
  logic [15:0] err_total;
  logic [31:0] bit_total;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] gs;
  logic       ep, lp, ep_after;

  m_seq_checker dut (
    .clk       (clk),
    .nCR       (nCR),
    .bit_in    (bit_in),
    .bit_en    (bit_en),
    .clr       (clr),
    .locked    (locked),
    .state     (state),
    .err_pulse (err_pulse),
    .loss_pulse(loss_pulse),
    .err_total (err_total),
    .bit_total (bit_total)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic gen_bit(output logic b);
    b  = gs[0];
    gs = gs >> 1;
    if (b) gs = gs ^ 8'h8E;
  endtask

  // one strobe then five idle clocks; ends 1 unit after a rising edge
  task automatic strobe(input logic b, input logic c);
    bit_in = b;
    clr    = c;
    bit_en = 1'b1;
    @(posedge clk); #1;
    ep = err_pulse;
    lp = loss_pulse;
    bit_en = 1'b0;
    clr    = 1'b0;
    @(posedge clk); #1;
    ep_after = err_pulse | loss_pulse;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic inv);
    logic b;
    gen_bit(b);
    strobe(b ^ inv, 1'b0);
  endtask

  task automatic do_reset();
    nCR = 1'b0;
    gs  = 8'h01;
    repeat (2) @(posedge clk);
    #1 nCR = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 nCR = 1'b0;
    #1;
    n_chk++;
    if ({locked, state, err_pulse, loss_pulse} !== 5'd0) begin
      $display("FAIL reset_flags: got %b required 00000",
               {locked, state, err_pulse, loss_pulse});
      n_fail++;
    end
    n_chk++;
    if (err_total !== 16'd0 || bit_total !== 32'd0) begin
      $display("FAIL reset_totals: got %0d/%0d required 0/0",
               err_total, bit_total);
      n_fail++;
    end
  endtask

  task automatic test_acquire();
    int npulse;
    logic [1:0] exp_st;
    npulse = 0;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      send(1'b0);
      if (ep || lp || ep_after) npulse++;
      if (i == 7 || i == 8 || i == 23 || i == 24) begin
        exp_st = (i < 8) ? 2'd0 : (i < 24) ? 2'd1 : 2'd2;
        n_chk++;
        if (state !== exp_st) begin
          $display("FAIL acq_state@%0d: got %0d required %0d",
                   i, state, exp_st);
          n_fail++;
        end
        n_chk++;
        if (locked !== (i == 24)) begin
          $display("FAIL acq_locked@%0d: got %b required %b",
                   i, locked, (i == 24));
          n_fail++;
        end
      end
    end
    n_chk++;
    if (err_total !== 16'd0) begin
      $display("FAIL acq_err_total: got %0d required 0", err_total);
      n_fail++;
    end
    n_chk++;
    if (bit_total !== 32'd976) begin
      $display("FAIL acq_bit_total: got %0d required 976", bit_total);
      n_fail++;
    end
    n_chk++;
    if (npulse !== 0) begin
      $display("FAIL acq_pulses: got %0d required 0", npulse);
      n_fail++;
    end
  endtask

  task automatic test_single_error();
    int npulse;
    npulse = 0;
    send(1'b1);
    n_chk++;
    if (ep !== 1'b1 || ep_after !== 1'b0) begin
      $display("FAIL single_pulse: got %b%b required 10", ep, ep_after);
      n_fail++;
    end
    n_chk++;
    if (err_total !== 16'd1 || locked !== 1'b1) begin
      $display("FAIL single_count: got %0d/%b required 1/1",
               err_total, locked);
      n_fail++;
    end
    for (int i = 0; i < 50; i++) begin
      send(1'b0);
      if (ep || lp) npulse++;
    end
    n_chk++;
    if (npulse !== 0 || err_total !== 16'd1) begin
      $display("FAIL single_after: got %0d pulses err %0d required 0/1",
               npulse, err_total);
      n_fail++;
    end
    n_chk++;
    if (bit_total !== 32'd1027) begin
      $display("FAIL single_bits: got %0d required 1027", bit_total);
      n_fail++;
    end
  endtask

  task automatic test_burst();
    logic [1:0] exp_st;
    do_reset();
    for (int i = 0; i < 30; i++) send(1'b0);
    n_chk++;
    if (locked !== 1'b1) begin
      $display("FAIL burst_prelock: got %b required 1", locked);
      n_fail++;
    end
    for (int k = 1; k <= 8; k++) begin
      send(1'b1);
      n_chk++;
      if (err_total !== 16'(k)) begin
        $display("FAIL burst_err@%0d: got %0d required %0d",
                 k, err_total, k);
        n_fail++;
      end
      n_chk++;
      if (lp !== (k == 8)) begin
        $display("FAIL burst_loss@%0d: got %b required %b",
                 k, lp, (k == 8));
        n_fail++;
      end
    end
    n_chk++;
    if (state !== 2'd0 || locked !== 1'b0 || bit_total !== 32'd14) begin
      $display("FAIL burst_hunt: got st %0d lk %b bits %0d required 0/0/14",
               state, locked, bit_total);
      n_fail++;
    end
    for (int i = 1; i <= 24; i++) begin
      send(1'b0);
      if (i == 7 || i == 8 || i == 23 || i == 24) begin
        exp_st = (i < 8) ? 2'd0 : (i < 24) ? 2'd1 : 2'd2;
        n_chk++;
        if (state !== exp_st) begin
          $display("FAIL burst_relock@%0d: got %0d required %0d",
                   i, state, exp_st);
          n_fail++;
        end
      end
    end
    n_chk++;
    if (err_total !== 16'd8) begin
      $display("FAIL burst_keep: got %0d required 8", err_total);
      n_fail++;
    end
  endtask

  task automatic test_zeros();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      strobe(1'b0, 1'b0);
      if (state !== 2'd0 || locked !== 1'b0) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      $display("FAIL zeros_state: got %0d non-hunt strobes required 0", bad);
      n_fail++;
    end
    n_chk++;
    if (err_total !== 16'd0 || bit_total !== 32'd0) begin
      $display("FAIL zeros_totals: got %0d/%0d required 0/0",
               err_total, bit_total);
      n_fail++;
    end
  endtask

  task automatic test_verify_err();
    do_reset();
    for (int i = 0; i < 8; i++) send(1'b0);
    n_chk++;
    if (state !== 2'd1) begin
      $display("FAIL verr_verify: got %0d required 1", state);
      n_fail++;
    end
    for (int i = 0; i < 9; i++) send(1'b0);
    bit_in = 1'b0;
    begin
      logic b;
      gen_bit(b);
      bit_in = ~b;
    end
    bit_en = 1'b1;
    @(posedge clk); #1;
    bit_en = 1'b0;
    n_chk++;
    if (state !== 2'd0) begin
      $display("FAIL verr_drop: got %0d required 0", state);
      n_fail++;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 1; i <= 24; i++) begin
      send(1'b0);
      if (i == 23 || i == 24) begin
        n_chk++;
        if (locked !== (i == 24)) begin
          $display("FAIL verr_relock@%0d: got %b required %b",
                   i, locked, (i == 24));
          n_fail++;
        end
      end
    end
    n_chk++;
    if (err_total !== 16'd0) begin
      $display("FAIL verr_err_total: got %0d required 0", err_total);
      n_fail++;
    end
  endtask

  task automatic test_clr();
    logic b;
    for (int i = 0; i < 3; i++) send(1'b0);
    n_chk++;
    if (bit_total !== 32'd3) begin
      $display("FAIL clr_pre: got %0d required 3", bit_total);
      n_fail++;
    end
    gen_bit(b);
    strobe(~b, 1'b1);
    n_chk++;
    if (err_total !== 16'd0 || bit_total !== 32'd0) begin
      $display("FAIL clr_totals: got %0d/%0d required 0/0",
               err_total, bit_total);
      n_fail++;
    end
    n_chk++;
    if (ep !== 1'b1 || locked !== 1'b1) begin
      $display("FAIL clr_pulse: got %b lk %b required 1/1", ep, locked);
      n_fail++;
    end
    send(1'b0);
    n_chk++;
    if (bit_total !== 32'd1 || err_total !== 16'd0) begin
      $display("FAIL clr_after: got %0d/%0d required 1/0",
               bit_total, err_total);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_lock();
    logic b;
    gen_bit(b);
    bit_in = ~b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    bit_en = 1'b0;
    n_chk++;
    if (err_pulse !== 1'b1) begin
      $display("FAIL mid_prepulse: got %b required 1", err_pulse);
      n_fail++;
    end
    #2 nCR = 1'b0;
    #1;
    n_chk++;
    if ({locked, state, err_pulse, loss_pulse} !== 5'd0
        || err_total !== 16'd0 || bit_total !== 32'd0) begin
      $display("FAIL mid_reset: got %b %0d %0d required zeros",
               {locked, state, err_pulse, loss_pulse}, err_total, bit_total);
      n_fail++;
    end
    @(posedge clk); #1;
    nCR = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 24; i++) begin
      send(1'b0);
      if (i == 23 || i == 24) begin
        n_chk++;
        if (locked !== (i == 24)) begin
          $display("FAIL mid_relock@%0d: got %b required %b",
                   i, locked, (i == 24));
          n_fail++;
        end
      end
    end
  endtask

  initial begin
    gs = 8'h01;
    test_reset();
    test_acquire();
    test_single_error();
    test_burst();
    test_zeros();
    test_verify_err();
    test_clr();
    test_reset_mid_lock();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
